cmplx_div: RTL and testbench



---
 rtl/cmplx_div.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_cmplx_div.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cmplx_div.sv
// Serial fixed-point complex divider for per-subcarrier equalization.
// C = A * conj(B) / |B|^2. A single restoring divider resolves one quotient
// magnitude bit per cycle for the real and imaginary parts in parallel.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_tvalid / in_tready    operand handshake (ready only while idle)
//   in_tfirst / in_tlast     sideband captured at accept
//   a_re, a_im, b_re, b_im   signed operands (InputFractionalPoint frac bits)
//   out_tvalid / out_tready  result handshake
//   out_tfirst / out_tlast   sideband returned with the result
//   c_re, c_im               signed quotient (OutputFractionalPoint frac bits)
//   div_error                sticky divide-by-zero flag, cleared by reset
module cmplx_div #(
  parameter int unsigned InputBitWidth         = 16,
  parameter int unsigned InputFractionalPoint  = 12,
  parameter int unsigned OutputBitWidth        = 16,
  parameter int unsigned OutputFractionalPoint = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_tvalid,
  output logic                      in_tready,
  input  logic                      in_tfirst,
  input  logic                      in_tlast,
  input  logic [InputBitWidth-1:0]  a_re,
  input  logic [InputBitWidth-1:0]  a_im,
  input  logic [InputBitWidth-1:0]  b_re,
  input  logic [InputBitWidth-1:0]  b_im,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic                      out_tfirst,
  output logic                      out_tlast,
  output logic [OutputBitWidth-1:0] c_re,
  output logic [OutputBitWidth-1:0] c_im,
  output logic                      div_error
);

  localparam int unsigned W    = InputBitWidth;
  localparam int unsigned OW   = OutputBitWidth;
  localparam int unsigned OFP  = OutputFractionalPoint;
  localparam int unsigned PW   = 2 * W;          // product width
  localparam int unsigned NW   = PW + 1;         // numerator width (signed)
  localparam int unsigned NM   = NW + OFP;       // scaled numerator magnitude
  localparam int unsigned CW   = PW + OW - 1;    // compare width for D << (OW-1)
  localparam int unsigned DSW  = PW + OW - 2;    // divisor shifted to top quotient bit
  localparam int unsigned QW   = OW - 1;         // quotient magnitude bits
  localparam int unsigned CNTW = $clog2(OW);
  localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};

  // A and B share the same fractional point, so it cancels in the ratio.
  if (InputFractionalPoint >= InputBitWidth) begin : g_bad_frac
    $error("InputFractionalPoint must be below InputBitWidth");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_SUM,
    ST_DIV,
    ST_OUT
  } state_e;

  state_e state_q, state_d;

  logic signed [W-1:0]  a_re_q, a_im_q, b_re_q, b_im_q;
  logic signed [W-1:0]  a_re_d, a_im_d, b_re_d, b_im_d;
  logic                 first_q, last_q, first_d, last_d;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ir_d, p_ri_d;
  logic                 sgn_re_q, sgn_im_q, sgn_re_d, sgn_im_d;
  logic                 ovf_re_q, ovf_im_q, ovf_re_d, ovf_im_d;
  logic                 zero_q, zero_d;
  logic [NM-1:0]        rem_re_q, rem_im_q, rem_re_d, rem_im_d;
  logic [DSW-1:0]       dsh_q, dsh_d;
  logic [QW-1:0]        q_re_q, q_im_q, q_re_d, q_im_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [OW-1:0]        c_re_q, c_im_q, c_re_d, c_im_d;
  logic                 ofirst_q, olast_q, ofirst_d, olast_d;
  logic                 oval_q, oval_d;
  logic                 rdy_q, rdy_d;
  logic                 err_q, err_d;

  // Datapath intermediates
  logic signed [NW-1:0] nr_c, ni_c;
  logic [NW-1:0]        nr_mag_c, ni_mag_c;
  logic [NM-1:0]        nr_sh_c, ni_sh_c;
  logic signed [PW-1:0] sq_r_c, sq_i_c;
  logic [PW-1:0]        dd_c;
  logic                 tr_re_c, tr_im_c;
  logic [QW-1:0]        qf_re_c, qf_im_c;

  // Sign/saturate/zero formatting of one quotient component
  function automatic logic [OW-1:0] fmt(input logic [QW-1:0] q, input logic neg,
                                        input logic ovf, input logic zero);
    logic [OW-1:0] mag;
    mag = {1'b0, q};
    if (zero)     return '0;
    else if (ovf) return neg ? (~MAXV + OW'(1)) : MAXV;
    else          return neg ? (~mag + OW'(1)) : mag;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_re_q   <= '0;
      a_im_q   <= '0;
      b_re_q   <= '0;
      b_im_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      p_rr_q   <= '0;
      p_ii_q   <= '0;
      p_ir_q   <= '0;
      p_ri_q   <= '0;
      sgn_re_q <= 1'b0;
      sgn_im_q <= 1'b0;
      ovf_re_q <= 1'b0;
      ovf_im_q <= 1'b0;
      zero_q   <= 1'b0;
      rem_re_q <= '0;
      rem_im_q <= '0;
      dsh_q    <= '0;
      q_re_q   <= '0;
      q_im_q   <= '0;
      cnt_q    <= '0;
      c_re_q   <= '0;
      c_im_q   <= '0;
      ofirst_q <= 1'b0;
      olast_q  <= 1'b0;
      oval_q   <= 1'b0;
      rdy_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_re_q   <= a_re_d;
      a_im_q   <= a_im_d;
      b_re_q   <= b_re_d;
      b_im_q   <= b_im_d;
      first_q  <= first_d;
      last_q   <= last_d;
      p_rr_q   <= p_rr_d;
      p_ii_q   <= p_ii_d;
      p_ir_q   <= p_ir_d;
      p_ri_q   <= p_ri_d;
      sgn_re_q <= sgn_re_d;
      sgn_im_q <= sgn_im_d;
      ovf_re_q <= ovf_re_d;
      ovf_im_q <= ovf_im_d;
      zero_q   <= zero_d;
      rem_re_q <= rem_re_d;
      rem_im_q <= rem_im_d;
      dsh_q    <= dsh_d;
      q_re_q   <= q_re_d;
      q_im_q   <= q_im_d;
      cnt_q    <= cnt_d;
      c_re_q   <= c_re_d;
      c_im_q   <= c_im_d;
      ofirst_q <= ofirst_d;
      olast_q  <= olast_d;
      oval_q   <= oval_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    a_re_d   = a_re_q;
    a_im_d   = a_im_q;
    b_re_d   = b_re_q;
    b_im_d   = b_im_q;
    first_d  = first_q;
    last_d   = last_q;
    p_rr_d   = p_rr_q;
    p_ii_d   = p_ii_q;
    p_ir_d   = p_ir_q;
    p_ri_d   = p_ri_q;
    sgn_re_d = sgn_re_q;
    sgn_im_d = sgn_im_q;
    ovf_re_d = ovf_re_q;
    ovf_im_d = ovf_im_q;
    zero_d   = zero_q;
    rem_re_d = rem_re_q;
    rem_im_d = rem_im_q;
    dsh_d    = dsh_q;
    q_re_d   = q_re_q;
    q_im_d   = q_im_q;
    cnt_d    = cnt_q;
    c_re_d   = c_re_q;
    c_im_d   = c_im_q;
    ofirst_d = ofirst_q;
    olast_d  = olast_q;
    err_d    = err_q;

    // Numerators A*conj(B) and denominator |B|^2
    nr_c     = NW'(p_rr_q) + NW'(p_ii_q);
    ni_c     = NW'(p_ir_q) - NW'(p_ri_q);
    nr_mag_c = nr_c[NW-1] ? NW'(-nr_c) : NW'(nr_c);
    ni_mag_c = ni_c[NW-1] ? NW'(-ni_c) : NW'(ni_c);
    nr_sh_c  = NM'(nr_mag_c) << OFP;
    ni_sh_c  = NM'(ni_mag_c) << OFP;
    sq_r_c   = PW'(b_re_q) * PW'(b_re_q);
    sq_i_c   = PW'(b_im_q) * PW'(b_im_q);
    dd_c     = PW'($unsigned(sq_r_c)) + PW'($unsigned(sq_i_c));

    // Restoring trial subtraction against the shifted divisor
    tr_re_c  = CW'(rem_re_q) >= CW'(dsh_q);
    tr_im_c  = CW'(rem_im_q) >= CW'(dsh_q);
    qf_re_c  = {q_re_q[QW-2:0], tr_re_c};
    qf_im_c  = {q_im_q[QW-2:0], tr_im_c};

    case (state_q)
      ST_IDLE: begin
        if (in_tvalid) begin
          a_re_d  = $signed(a_re);
          a_im_d  = $signed(a_im);
          b_re_d  = $signed(b_re);
          b_im_d  = $signed(b_im);
          first_d = in_tfirst;
          last_d  = in_tlast;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        p_rr_d  = PW'(a_re_q) * PW'(b_re_q);
        p_ii_d  = PW'(a_im_q) * PW'(b_im_q);
        p_ir_d  = PW'(a_im_q) * PW'(b_re_q);
        p_ri_d  = PW'(a_re_q) * PW'(b_im_q);
        state_d = ST_SUM;
      end
      ST_SUM: begin
        sgn_re_d = nr_c[NW-1];
        sgn_im_d = ni_c[NW-1];
        rem_re_d = nr_sh_c;
        rem_im_d = ni_sh_c;
        // Quotient would not fit in OW-1 magnitude bits
        ovf_re_d = CW'(nr_sh_c) >= (CW'(dd_c) << (OW - 1));
        ovf_im_d = CW'(ni_sh_c) >= (CW'(dd_c) << (OW - 1));
        zero_d   = (dd_c == '0);
        dsh_d    = DSW'(dd_c) << (OW - 2);
        q_re_d   = '0;
        q_im_d   = '0;
        cnt_d    = CNTW'(OW - 2);
        state_d  = ST_DIV;
      end
      ST_DIV: begin
        if (tr_re_c) rem_re_d = NM'(CW'(rem_re_q) - CW'(dsh_q));
        if (tr_im_c) rem_im_d = NM'(CW'(rem_im_q) - CW'(dsh_q));
        q_re_d = qf_re_c;
        q_im_d = qf_im_c;
        dsh_d  = dsh_q >> 1;
        cnt_d  = cnt_q - CNTW'(1);
        if (cnt_q == '0) begin
          c_re_d   = fmt(qf_re_c, sgn_re_q, ovf_re_q, zero_q);
          c_im_d   = fmt(qf_im_c, sgn_im_q, ovf_im_q, zero_q);
          ofirst_d = first_q;
          olast_d  = last_q;
          err_d    = err_q | zero_q;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d  = (state_d == ST_IDLE);
    oval_d = (state_d == ST_OUT);
  end

  assign in_tready  = rdy_q;
  assign out_tvalid = oval_q;
  assign out_tfirst = ofirst_q;
  assign out_tlast  = olast_q;
  assign c_re       = c_re_q;
  assign c_im       = c_im_q;
  assign div_error  = err_q;

endmodule

// File: tb/tb_cmplx_div.sv
// Directed bench for cmplx_div: table of operations with hand-computed
// quotients, plus sequences for output stall and reset during division.
module tb_cmplx_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_tvalid, in_tready, in_tfirst, in_tlast;
  logic [15:0] a_re, a_im, b_re, b_im;
  logic        out_tvalid, out_tready, out_tfirst, out_tlast;
  logic [15:0] c_re, c_im;
  logic        div_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmplx_div dut (
    .clk        (clk),
    .reset      (reset),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tfirst  (in_tfirst),
    .in_tlast   (in_tlast),
    .a_re       (a_re),
    .a_im       (a_im),
    .b_re       (b_re),
    .b_im       (b_im),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tfirst (out_tfirst),
    .out_tlast  (out_tlast),
    .c_re       (c_re),
    .c_im       (c_im),
    .div_error  (div_error)
  );

  typedef struct {
    int   ar, ai, br, bi;
    logic first, last;
    int   er, ei;
    logic err;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi,
                       input logic f, input logic l);
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
    in_tfirst = f; in_tlast = l; in_tvalid = 1'b1;
  endtask

  // One operation: accept, measure latency, check result, complete handshake
  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic busy_ok;
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d in_tready_idle", idx), int'(in_tready), 1);
    drive(v.ar, v.ai, v.br, v.bi, v.first, v.last);
    @(negedge clk);
    in_tvalid = 1'b0;
    while (!out_tvalid && n < 40) begin
      if (in_tready) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d latency", idx), n, 17);
    chk($sformatf("v%0d in_tready_busy", idx), int'(busy_ok), 1);
    chk($sformatf("v%0d c_re", idx), int'($signed(c_re)), v.er);
    chk($sformatf("v%0d c_im", idx), int'($signed(c_im)), v.ei);
    chk($sformatf("v%0d out_tfirst", idx), int'(out_tfirst), int'(v.first));
    chk($sformatf("v%0d out_tlast", idx), int'(out_tlast), int'(v.last));
    chk($sformatf("v%0d div_error", idx), int'(div_error), int'(v.err));
    @(negedge clk);
    chk($sformatf("v%0d out_tvalid_drop", idx), int'(out_tvalid), 0);
    chk($sformatf("v%0d in_tready_back", idx), int'(in_tready), 1);
  endtask

  initial begin
    vec_t vecs[10];
    int   n;
    logic seen;

    //        ar     ai     br     bi    f     l     er      ei    err
    vecs[0] = '{ 4096,     0,  4096,     0, 1'b1, 1'b0,     64,      0, 1'b0};
    vecs[1] = '{ 4096,  4096,  4096, -4096, 1'b0, 1'b0,      0,     64, 1'b0};
    vecs[2] = '{-4096,     0, 12288,     0, 1'b0, 1'b1,    -21,      0, 1'b0};
    vecs[3] = '{ 4096, -4096,     1,     0, 1'b1, 1'b1,  32767, -32767, 1'b0};
    vecs[4] = '{    0, -4096,  4096,     0, 1'b0, 1'b0,      0,    -64, 1'b0};
    vecs[5] = '{ 2048,  1024,     0,  4096, 1'b1, 1'b0,     16,    -32, 1'b0};
    vecs[6] = '{ 4096,     0,-12288,     0, 1'b0, 1'b1,    -21,      0, 1'b0};
    vecs[7] = '{    0,     0,  4096,  4096, 1'b0, 1'b0,      0,      0, 1'b0};
    vecs[8] = '{ 4096,  4096,     0,     0, 1'b1, 1'b1,      0,      0, 1'b1};
    vecs[9] = '{ 4096,     0,  4096,     0, 1'b0, 1'b1,     64,      0, 1'b1};

    reset = 1'b1;
    in_tvalid = 1'b0; in_tfirst = 1'b0; in_tlast = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    out_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst in_tready", int'(in_tready), 1);
    chk("rst out_tvalid", int'(out_tvalid), 0);
    chk("rst c_re", int'(c_re), 0);
    chk("rst c_im", int'(c_im), 0);
    chk("rst out_tfirst", int'(out_tfirst), 0);
    chk("rst out_tlast", int'(out_tlast), 0);
    chk("rst div_error", int'(div_error), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Output stall: result held while out_tready is low
    out_tready = 1'b0;
    @(negedge clk);
    drive(-4096, 0, 12288, 0, 1'b0, 1'b1);
    @(negedge clk);
    in_tvalid = 1'b0;
    n = 0;
    while (!out_tvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("stall latency", n, 17);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d out_tvalid", k), int'(out_tvalid), 1);
      chk($sformatf("stall%0d c_re", k), int'($signed(c_re)), -21);
      chk($sformatf("stall%0d c_im", k), int'($signed(c_im)), 0);
      chk($sformatf("stall%0d out_tlast", k), int'(out_tlast), 1);
      chk($sformatf("stall%0d in_tready", k), int'(in_tready), 0);
      @(negedge clk);
    end
    out_tready = 1'b1;
    @(negedge clk);
    chk("stall release out_tvalid", int'(out_tvalid), 0);
    chk("stall release in_tready", int'(in_tready), 1);

    // Reset while dividing: no beat, everything back to reset values
    drive(4096, 4096, 4096, 0, 1'b1, 1'b1);
    @(negedge clk);
    in_tvalid = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort out_tvalid", int'(out_tvalid), 0);
    chk("abort in_tready", int'(in_tready), 1);
    chk("abort c_re", int'(c_re), 0);
    chk("abort c_im", int'(c_im), 0);
    chk("abort out_tfirst", int'(out_tfirst), 0);
    chk("abort out_tlast", int'(out_tlast), 0);
    chk("abort div_error", int'(div_error), 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_tvalid) seen = 1'b1;
    end
    chk("abort no beat", int'(seen), 0);

    // Normal operation after the abort
    run_vec(vecs[1], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
